// File: rtl/playfield_gate_draw.sv
// Playfield wall renderer with NUM_GATES independently timed gate walls.
// Draw outputs are registered one cycle behind pixelX/pixelY/levelRGB.
module playfield_gate_draw #(
    parameter int NUM_GATES     = 2,
    parameter int LEFT_WALL     = 10,
    parameter int RIGHT_WALL    = 445,
    parameter int UP_WALL       = 30,
    parameter int BOTTOM_WALL   = 430,
    parameter int GAP_X0        = 10,
    parameter int GAP_X1        = 408,
    parameter logic [NUM_GATES*11-1:0] GATE_X0 = {11'd200, 11'd380},
    parameter logic [NUM_GATES*11-1:0] GATE_X1 = {11'd220, 11'd400},
    parameter logic [NUM_GATES*11-1:0] GATE_Y0 = {11'd200, 11'd100},
    parameter logic [NUM_GATES*11-1:0] GATE_Y1 = {11'd210, 11'd110},
    parameter int CLOSE_FRAMES  = 15,
    parameter int REOPEN_FRAMES = 0
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 startOfFrame,
    input  logic                 new_game,
    input  logic [NUM_GATES-1:0] gate_trig,
    input  logic [7:0]           levelRGB,
    output logic [7:0]           BG_RGB,
    output logic                 boardersDR,
    output logic [NUM_GATES-1:0] gateDR,
    output logic [NUM_GATES-1:0] gate_closed
);

    localparam logic [10:0] L_LEFT   = 11'(LEFT_WALL);
    localparam logic [10:0] L_RIGHT  = 11'(RIGHT_WALL);
    localparam logic [10:0] L_UP     = 11'(UP_WALL);
    localparam logic [10:0] L_BOTTOM = 11'(BOTTOM_WALL);
    localparam logic [10:0] L_GAP_X0 = 11'(GAP_X0);
    localparam logic [10:0] L_GAP_X1 = 11'(GAP_X1);
    localparam logic [7:0]  L_CLOSE  = 8'(CLOSE_FRAMES);
    localparam logic [7:0]  L_REOPEN = 8'(REOPEN_FRAMES);

    typedef enum logic [1:0] {
        S_OPEN   = 2'd0,
        S_ARMED  = 2'd1,
        S_CLOSED = 2'd2
    } gate_state_t;

    gate_state_t          r_state     [NUM_GATES];
    gate_state_t          w_state_nxt [NUM_GATES];
    logic [7:0]           r_cnt       [NUM_GATES];
    logic [7:0]           w_cnt_nxt   [NUM_GATES];
    logic [NUM_GATES-1:0] r_used;
    logic [NUM_GATES-1:0] w_used_nxt;

    logic [NUM_GATES-1:0] w_gate_hit;
    logic                 w_static;
    logic                 w_border;

    logic [7:0]           r_bg_rgb;
    logic                 r_border;
    logic [NUM_GATES-1:0] r_gate_dr;
    logic [NUM_GATES-1:0] r_gate_closed;

    // Per-gate next state; new_game outranks any transition or trigger.
    always_comb begin
        w_used_nxt = r_used;
        for (int g = 0; g < NUM_GATES; g++) begin
            w_state_nxt[g] = r_state[g];
            w_cnt_nxt[g]   = r_cnt[g];
            if (new_game) begin
                w_state_nxt[g] = S_OPEN;
                w_cnt_nxt[g]   = 8'd0;
                w_used_nxt[g]  = 1'b0;
            end else begin
                case (r_state[g])
                    S_OPEN: begin
                        if (gate_trig[g] && !r_used[g]) begin
                            w_state_nxt[g] = S_ARMED;
                            w_cnt_nxt[g]   = 8'd0;
                            w_used_nxt[g]  = 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (L_CLOSE == 8'd0) begin
                            w_state_nxt[g] = S_CLOSED;
                            w_cnt_nxt[g]   = 8'd0;
                        end else if (startOfFrame) begin
                            if (r_cnt[g] + 8'd1 == L_CLOSE) begin
                                w_state_nxt[g] = S_CLOSED;
                                w_cnt_nxt[g]   = 8'd0;
                            end else begin
                                w_cnt_nxt[g] = r_cnt[g] + 8'd1;
                            end
                        end
                    end
                    S_CLOSED: begin
                        if (L_REOPEN != 8'd0 && startOfFrame) begin
                            if (r_cnt[g] + 8'd1 == L_REOPEN) begin
                                w_state_nxt[g] = S_OPEN;
                                w_cnt_nxt[g]   = 8'd0;
                                w_used_nxt[g]  = 1'b0;
                            end else begin
                                w_cnt_nxt[g] = r_cnt[g] + 8'd1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt[g] = S_OPEN;
                        w_cnt_nxt[g]   = 8'd0;
                        w_used_nxt[g]  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int g = 0; g < NUM_GATES; g++) begin
                r_state[g] <= S_OPEN;
                r_cnt[g]   <= 8'd0;
            end
            r_used <= '0;
        end else begin
            for (int g = 0; g < NUM_GATES; g++) begin
                r_state[g] <= w_state_nxt[g];
                r_cnt[g]   <= w_cnt_nxt[g];
            end
            r_used <= w_used_nxt;
        end
    end

    // Gate hits use the gate state present in the same cycle as the pixel.
    always_comb begin
        w_static = (pixelX < L_LEFT) || (pixelY < L_UP) || (pixelX > L_RIGHT) ||
                   ((pixelY == L_BOTTOM) && !((pixelX >= L_GAP_X0) && (pixelX <= L_GAP_X1)));
        for (int g = 0; g < NUM_GATES; g++) begin
            w_gate_hit[g] = (pixelX >= GATE_X0[g*11 +: 11]) && (pixelX <= GATE_X1[g*11 +: 11]) &&
                            (pixelY >= GATE_Y0[g*11 +: 11]) && (pixelY <= GATE_Y1[g*11 +: 11]) &&
                            (r_state[g] == S_CLOSED);
        end
        w_border = w_static || (|w_gate_hit);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_bg_rgb      <= 8'h00;
            r_border      <= 1'b0;
            r_gate_dr     <= '0;
            r_gate_closed <= '0;
        end else begin
            r_bg_rgb  <= w_border ? levelRGB : 8'h00;
            r_border  <= w_border;
            r_gate_dr <= w_gate_hit;
            for (int g = 0; g < NUM_GATES; g++) begin
                r_gate_closed[g] <= (r_state[g] == S_CLOSED);
            end
        end
    end

    assign BG_RGB      = r_bg_rgb;
    assign boardersDR  = r_border;
    assign gateDR      = r_gate_dr;
    assign gate_closed = r_gate_closed;

endmodule

// File: tb/tb_playfield_gate_draw.sv
// Directed bench for playfield_gate_draw: default instance plus a
// CLOSE_FRAMES=2 / REOPEN_FRAMES=4 instance for the auto-reopen path.
module tb_playfield_gate_draw;

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        new_game;
    logic [1:0]  gate_trig;
    logic [1:0]  gate_trig_b;
    logic [7:0]  levelRGB;

    logic [7:0]  BG_RGB;
    logic        boardersDR;
    logic [1:0]  gateDR;
    logic [1:0]  gate_closed;
    logic [7:0]  BG_RGB_b;
    logic        boardersDR_b;
    logic [1:0]  gateDR_b;
    logic [1:0]  gate_closed_b;

    int n_checks = 0;
    int n_errors = 0;

    playfield_gate_draw u_dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .new_game(new_game), .gate_trig(gate_trig),
        .levelRGB(levelRGB), .BG_RGB(BG_RGB), .boardersDR(boardersDR),
        .gateDR(gateDR), .gate_closed(gate_closed)
    );

    playfield_gate_draw #(.CLOSE_FRAMES(2), .REOPEN_FRAMES(4)) u_dut_re (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .new_game(new_game), .gate_trig(gate_trig_b),
        .levelRGB(levelRGB), .BG_RGB(BG_RGB_b), .boardersDR(boardersDR_b),
        .gateDR(gateDR_b), .gate_closed(gate_closed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick(1);
            startOfFrame = 1'b0;
            tick(1);
        end
    endtask

    task automatic set_pix(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick(1);
    endtask

    // Static wall table: x, y, expected boardersDR
    int tx [12] = '{5, 200, 420, 9, 10, 445, 446, 100, 100, 408, 409, 380};
    int ty [12] = '{200, 430, 430, 100, 100, 100, 100, 29, 30, 430, 430, 100};
    logic te [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0};

    initial begin
        resetN = 1'b0; pixelX = 11'd200; pixelY = 11'd100; startOfFrame = 1'b0;
        new_game = 1'b0; gate_trig = 2'b00; gate_trig_b = 2'b00; levelRGB = 8'h1C;
        #23;
        check_eq("rst_bg", 32'(BG_RGB), 32'h00);
        check_eq("rst_border", 32'(boardersDR), 32'h0);
        check_eq("rst_gatedr", 32'(gateDR), 32'h0);
        check_eq("rst_closed", 32'(gate_closed), 32'h0);
        @(posedge clk); #1;
        resetN = 1'b1;
        tick(1);

        // Static walls and the flipper gap
        for (int i = 0; i < 12; i++) begin
            set_pix(tx[i], ty[i]);
            check_eq($sformatf("wall_border_%0d", i), 32'(boardersDR), 32'(te[i]));
            check_eq($sformatf("wall_bg_%0d", i), 32'(BG_RGB), te[i] ? 32'h1C : 32'h00);
        end

        // Reset while gate 0 is ARMED with cnt=7
        gate_trig[0] = 1'b1; tick(1); gate_trig[0] = 1'b0;
        frame(7);
        set_pix(5, 200);
        check_eq("pre_rst_bg", 32'(BG_RGB), 32'h1C);
        resetN = 1'b0;
        #1;
        check_eq("async_rst_bg", 32'(BG_RGB), 32'h00);
        check_eq("async_rst_border", 32'(boardersDR), 32'h0);
        @(posedge clk); #1;
        resetN = 1'b1;
        set_pix(200, 100);
        frame(15);
        check_eq("no_resume", 32'(gate_closed), 32'h0);

        // Close after exactly CLOSE_FRAMES frames
        gate_trig[0] = 1'b1; tick(1); gate_trig[0] = 1'b0;
        frame(14);
        check_eq("close_14", 32'(gate_closed), 32'h0);
        frame(1);
        check_eq("close_15", 32'(gate_closed), 32'h1);
        levelRGB = 8'hE3;
        set_pix(380, 100);
        check_eq("gate0_dr", 32'(gateDR), 32'h1);
        check_eq("gate0_border", 32'(boardersDR), 32'h1);
        check_eq("gate0_bg", 32'(BG_RGB), 32'hE3);
        set_pix(400, 110);
        check_eq("gate0_corner", 32'(gateDR), 32'h1);
        set_pix(401, 110);
        check_eq("gate0_outside", 32'(gateDR), 32'h0);
        check_eq("gate0_out_border", 32'(boardersDR), 32'h0);
        gate_trig[0] = 1'b1; tick(1); gate_trig[0] = 1'b0;
        frame(20);
        check_eq("stay_closed", 32'(gate_closed), 32'h1);

        // new_game beats a same-cycle trigger and frame tick
        new_game = 1'b1; gate_trig[1] = 1'b1; startOfFrame = 1'b1;
        tick(1);
        new_game = 1'b0; gate_trig[1] = 1'b0; startOfFrame = 1'b0;
        tick(1);
        check_eq("ng_open", 32'(gate_closed), 32'h0);
        set_pix(380, 100);
        check_eq("ng_gatedr", 32'(gateDR), 32'h0);
        frame(16);
        check_eq("ng_g1_not_armed", 32'(gate_closed), 32'h0);
        gate_trig[1] = 1'b1; tick(1); gate_trig[1] = 1'b0;
        frame(15);
        check_eq("ng_rearm", 32'(gate_closed), 32'h2);

        // Independent gates, triggers three frames apart; first trigger rides a tick
        new_game = 1'b1; tick(1); new_game = 1'b0; tick(1);
        gate_trig[0] = 1'b1; startOfFrame = 1'b1; tick(1);
        gate_trig[0] = 1'b0; startOfFrame = 1'b0; tick(1);
        frame(3);
        gate_trig[1] = 1'b1; tick(1); gate_trig[1] = 1'b0;
        frame(11);
        check_eq("indep_14", 32'(gate_closed), 32'h0);
        frame(1);
        check_eq("indep_15", 32'(gate_closed), 32'h1);
        frame(2);
        check_eq("indep_17", 32'(gate_closed), 32'h1);
        frame(1);
        check_eq("indep_18", 32'(gate_closed), 32'h3);
        set_pix(210, 205);
        check_eq("gate1_dr", 32'(gateDR), 32'h2);
        set_pix(390, 105);
        check_eq("gate0_dr_b", 32'(gateDR), 32'h1);

        // Auto-reopen instance
        gate_trig_b[0] = 1'b1; tick(1); gate_trig_b[0] = 1'b0;
        frame(1);
        check_eq("re_close_1", 32'(gate_closed_b), 32'h0);
        frame(1);
        check_eq("re_close_2", 32'(gate_closed_b), 32'h1);
        frame(3);
        check_eq("re_open_3", 32'(gate_closed_b), 32'h1);
        frame(1);
        check_eq("re_open_4", 32'(gate_closed_b), 32'h0);
        gate_trig_b[0] = 1'b1; tick(1); gate_trig_b[0] = 1'b0;
        frame(1);
        check_eq("re_again_1", 32'(gate_closed_b), 32'h0);
        frame(1);
        check_eq("re_again_2", 32'(gate_closed_b), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/playfield_gate_draw.md
Name: playfield_gate_draw

Overview:
Parameterised successor of the single-gate background/wall renderer. It draws the static playfield walls and NUM_GATES independently timed gate walls, such as the launch-lane gate, in the wall colour (levelRGB). Each gate has its own trigger and a frame-counted close delay, with an optional auto-reopen. It sits in the video object path before the priority mux and feeds boardersDR to collision logic.

Parameters:
NUM_GATES, 2, number of independent gate channels (1..8)
LEFT_WALL, 10, x < LEFT_WALL is wall
RIGHT_WALL, 445, x > RIGHT_WALL is wall
UP_WALL, 30, y < UP_WALL is wall
BOTTOM_WALL, 430, bottom wall row (single line)
GAP_X0 / GAP_X1, 10 / 408, bottom wall not drawn for GAP_X0 <= x <= GAP_X1 (flipper gap)
GATE_X0, GATE_X1, GATE_Y0, GATE_Y1, packed NUM_GATES x 11 bit each, inclusive rectangle of gate g
CLOSE_FRAMES, 15, frames from trigger until gate closes (0..255)
REOPEN_FRAMES, 0, frames a closed gate stays closed; 0 = stays closed until new_game

Ports:
clk  in  1  pixel clock
resetN  in  1  asynchronous active-low reset
pixelX  in  11  current pixel x
pixelY  in  11  current pixel y
startOfFrame  in  1  one-cycle pulse per frame
new_game  in  1  level restart; reopens all gates
gate_trig  in  NUM_GATES  per-gate trigger (ball hit sensor)
levelRGB  in  8  wall colour for current pixel
BG_RGB  out  8  background colour, registered
boardersDR  out  1  pixel is static wall or closed gate, registered
gateDR  out  NUM_GATES  pixel inside closed gate g, registered
gate_closed  out  NUM_GATES  gate g state == CLOSED

Behaviour:
- Reset (async, resetN=0): BG_RGB=0x00, boardersDR=0, gateDR=0, gate_closed=0, all gates OPEN, all counters 0, all used flags 0.
- Draw path, 1-cycle latency from pixelX/pixelY/levelRGB:
  - static = (x<LEFT_WALL) | (y<UP_WALL) | (x>RIGHT_WALL) | (y==BOTTOM_WALL & !(GAP_X0<=x<=GAP_X1)).
  - gateDR[g] = pixel in rect g & state[g]==CLOSED. Gate state is sampled the same cycle as the pixel.
  - boardersDR = static | (|gateDR); BG_RGB = levelRGB if boardersDR, else 0x00.
- Per-gate FSM, states OPEN, ARMED, CLOSED; 8-bit frame counter cnt[g]:
  - OPEN: gate_trig[g] & !used[g] -> ARMED, cnt=0, used=1. Trigger while used=1 is ignored.
  - ARMED: each startOfFrame increments cnt. When the incremented value == CLOSE_FRAMES -> CLOSED, cnt=0. CLOSE_FRAMES=0 -> CLOSED on the cycle after the trigger, no frame needed. Triggers are ignored in this state.
  - CLOSED: if REOPEN_FRAMES=0, stay. Otherwise each startOfFrame increments cnt; reaching REOPEN_FRAMES -> OPEN, cnt=0, used=0, so the gate can re-arm.
  - gate_closed[g] is registered: high the cycle after entering CLOSED.
- Priority per cycle: new_game > state transition > trigger.
  - new_game=1 forces all gates to OPEN, cnt=0, used=0 at the next edge, overriding a same-cycle trigger or frame tick.
  - Trigger and startOfFrame in the same cycle in OPEN: enter ARMED with cnt=0; the tick is not counted.
- Gates are fully independent; simultaneous triggers on several gates are each honoured.
- Counter never wraps; it saturates at its terminal compare.
- Overlapping rectangles: each gateDR bit is reported independently; boardersDR is the OR.

Test Plan:
- Reset mid-frame with gate 0 ARMED (cnt=7): assert resetN=0 -> all outputs 0 immediately, gate OPEN; the previous trigger does not resume.
- Pixel (5,200), levelRGB=0x1C -> next cycle BG_RGB=0x1C, boardersDR=1. Pixel (200,430) in the gap -> BG_RGB=0x00, boardersDR=0.
- CLOSE_FRAMES=15: pulse gate_trig[0], then 14 startOfFrame -> gate_closed[0]=0; 15th -> gate_closed[0]=1 next cycle. Pixel at GATE_X0[0],GATE_Y0[0] -> gateDR[0]=1, BG_RGB=levelRGB. Second trigger ignored.
- new_game same cycle as gate_trig[1] and startOfFrame with gate 0 CLOSED -> both gates OPEN, gate 1 not ARMED, gate_closed=0. A later trigger re-arms.
- REOPEN_FRAMES=4, CLOSE_FRAMES=2: trigger, 2 frames -> CLOSED; 4 frames -> OPEN. Retrigger -> closes again after 2 frames.
- Triggers on gates 0 and 1 three frames apart -> closures occur three frames apart; gateDR bits independent.
